// File: rtl/data_mem_dp_if.sv
// Bus bundle for the data memory: port A (core pipeline, never stalled) and
// port B (valid/ready loader/debug requests with a one-cycle response pulse).
interface data_mem_dp_if;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wr_byte_en;
    logic [31:0] mem_wr_data;
    logic        mem_rst;
    logic [31:0] mem_rd_data;
    logic        mem_fault;

    // Port B handshake: a request transfers on an edge where b_req_valid and
    // b_req_ready are both high; the requester holds every b_req_* field stable
    // while valid is high and ready is low. b_rsp_valid is a single-cycle pulse,
    // and b_rsp_rdata/b_rsp_fault keep their values until the next response.
    logic        b_req_valid;
    logic        b_req_ready;
    logic        b_req_we;
    logic [31:0] b_req_addr;
    logic [3:0]  b_req_be;
    logic [31:0] b_req_wdata;
    logic        b_rsp_valid;
    logic [31:0] b_rsp_rdata;
    logic        b_rsp_fault;

    modport master (
        output mem_addr, mem_wr_byte_en, mem_wr_data, mem_rst,
        input  mem_rd_data, mem_fault,
        output b_req_valid, b_req_we, b_req_addr, b_req_be, b_req_wdata,
        input  b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_fault
    );

    modport slave (
        input  mem_addr, mem_wr_byte_en, mem_wr_data, mem_rst,
        output mem_rd_data, mem_fault,
        input  b_req_valid, b_req_we, b_req_addr, b_req_be, b_req_wdata,
        output b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_fault
    );
endinterface

// File: rtl/data_mem_dp.sv
// True dual-port, read-first, byte-writable data RAM. Port A serves the core
// every cycle; port B is a loader/debug port with a two-state response FSM.
module data_mem_dp #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic          Clk,
    input  logic          Reset_n,
    data_mem_dp_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [0:0] {B_IDLE, B_RESP} b_state_t;

    b_state_t    state;
    b_state_t    state_next;

    logic [31:0] mem [DEPTH_WORDS];

    logic [29:0]   a_woff;
    logic [29:0]   b_woff;
    logic          a_in;
    logic          b_in;
    logic [AW-1:0] a_idx;
    logic [AW-1:0] b_idx;
    logic          a_wr_en;
    logic          b_wr_en;
    logic          collision;
    logic          ready;
    logic          b_fire;

    // Word offsets are taken on bits [31:2] only; BASE_ADDR is depth-aligned, so
    // an address at or above the base is in range iff the offset's high bits are 0.
    assign a_woff = bus.mem_addr[31:2]   - BASE_ADDR[31:2];
    assign b_woff = bus.b_req_addr[31:2] - BASE_ADDR[31:2];
    assign a_in   = (bus.mem_addr   >= BASE_ADDR) && (a_woff[29:AW] == '0);
    assign b_in   = (bus.b_req_addr >= BASE_ADDR) && (b_woff[29:AW] == '0);
    assign a_idx  = a_woff[AW-1:0];
    assign b_idx  = b_woff[AW-1:0];

    assign a_wr_en = a_in && !bus.mem_rst && (|bus.mem_wr_byte_en);

    // Same-word write conflict: port A always wins and B keeps its request up.
    assign collision = bus.b_req_valid && bus.b_req_we && (|bus.mem_wr_byte_en)
                       && a_in && b_in && (a_idx == b_idx);

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        case (state)
            B_IDLE: begin
                ready = !collision;
                if (bus.b_req_valid && !collision) state_next = B_RESP;
            end
            B_RESP: state_next = B_IDLE;
            default: state_next = B_IDLE;
        endcase
    end

    // Held low while reset is asserted; otherwise purely state plus collision.
    assign bus.b_req_ready = ready && Reset_n;
    assign b_fire          = bus.b_req_valid && bus.b_req_ready;
    assign b_wr_en         = b_fire && bus.b_req_we && b_in;
    assign bus.b_rsp_valid = (state == B_RESP);

    // Array contents are deliberately not reset so this maps onto block RAM.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (a_wr_en && bus.mem_wr_byte_en[i])
                mem[a_idx][8*i +: 8] <= bus.mem_wr_data[8*i +: 8];
            if (b_wr_en && bus.b_req_be[i])
                mem[b_idx][8*i +: 8] <= bus.b_req_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.mem_rd_data <= '0;
            bus.mem_fault   <= 1'b0;
        end else if (bus.mem_rst) begin
            bus.mem_rd_data <= '0;
            bus.mem_fault   <= 1'b0;
        end else if (!a_in) begin
            bus.mem_rd_data <= '0;
            bus.mem_fault   <= 1'b1;
        end else begin
            bus.mem_rd_data <= mem[a_idx];
            bus.mem_fault   <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state           <= B_IDLE;
            bus.b_rsp_rdata <= '0;
            bus.b_rsp_fault <= 1'b0;
        end else begin
            state <= state_next;
            if (b_fire) begin
                bus.b_rsp_rdata <= (!bus.b_req_we && b_in) ? mem[b_idx] : 32'h0;
                bus.b_rsp_fault <= !b_in;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_dp.sv
// Directed bench for data_mem_dp: a reference memory model predicts port A read
// data, B handshake and B responses; expectations flow through queues.
module tb_data_mem_dp;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;

    always #5 Clk = ~Clk;

    data_mem_dp_if bus ();

    data_mem_dp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    logic [31:0] model [DEPTH];
    logic        known [DEPTH];
    // Entry layout: [33] data is checkable, [32] fault, [31:0] data.
    logic [33:0] exp_a_q [$];
    logic [33:0] exp_b_q [$];
    logic        b_busy;
    logic [31:0] last_rdata;
    logic        last_fault;
    logic        last_chk;
    int          total = 0;
    int          bad   = 0;

    function automatic logic in_rng(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'(DEPTH * 4));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input logic rst);
        bus.mem_addr       = addr;
        bus.mem_wr_byte_en = be;
        bus.mem_wr_data    = wd;
        bus.mem_rst        = rst;
    endtask

    task automatic set_b(input logic v, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        bus.b_req_valid = v;
        bus.b_req_we    = we;
        bus.b_req_addr  = addr;
        bus.b_req_be    = be;
        bus.b_req_wdata = wd;
    endtask

    // One clock cycle: called just after a rising edge with inputs already set.
    task automatic step(input string tag);
        logic        a_in, b_in, coll, rdy_exp, acc;
        int          ai, bi;
        logic [33:0] e;
        #3;
        a_in = in_rng(bus.mem_addr);
        b_in = in_rng(bus.b_req_addr);
        ai   = a_in ? widx(bus.mem_addr) : 0;
        bi   = b_in ? widx(bus.b_req_addr) : 0;
        coll = bus.b_req_valid && bus.b_req_we && (|bus.mem_wr_byte_en)
               && a_in && b_in && (ai == bi);
        rdy_exp = !b_busy && !coll;
        check({tag, ".b_req_ready"}, 32'(bus.b_req_ready), 32'(rdy_exp));
        acc = bus.b_req_valid && rdy_exp;

        if (bus.mem_rst)  exp_a_q.push_back({1'b1, 1'b0, 32'h0});
        else if (!a_in)   exp_a_q.push_back({1'b1, 1'b1, 32'h0});
        else              exp_a_q.push_back({known[ai], 1'b0, model[ai]});

        if (acc) begin
            if (!b_in)             exp_b_q.push_back({1'b1, 1'b1, 32'h0});
            else if (bus.b_req_we) exp_b_q.push_back({1'b1, 1'b0, 32'h0});
            else                   exp_b_q.push_back({known[bi], 1'b0, model[bi]});
        end

        if (!bus.mem_rst && a_in && (|bus.mem_wr_byte_en)) begin
            for (int i = 0; i < 4; i++)
                if (bus.mem_wr_byte_en[i]) model[ai][8*i +: 8] = bus.mem_wr_data[8*i +: 8];
            if (bus.mem_wr_byte_en == 4'hF) known[ai] = 1'b1;
        end
        if (acc && bus.b_req_we && b_in) begin
            for (int i = 0; i < 4; i++)
                if (bus.b_req_be[i]) model[bi][8*i +: 8] = bus.b_req_wdata[8*i +: 8];
            if (bus.b_req_be == 4'hF) known[bi] = 1'b1;
        end
        b_busy = acc;

        @(posedge Clk);
        #1;
        e = exp_a_q.pop_front();
        check({tag, ".mem_fault"}, 32'(bus.mem_fault), 32'(e[32]));
        if (e[33]) check({tag, ".mem_rd_data"}, bus.mem_rd_data, e[31:0]);
        check({tag, ".b_rsp_valid"}, 32'(bus.b_rsp_valid), 32'(b_busy));
        if (b_busy) begin
            e          = exp_b_q.pop_front();
            last_chk   = e[33];
            last_fault = e[32];
            last_rdata = e[31:0];
        end
        check({tag, ".b_rsp_fault"}, 32'(bus.b_rsp_fault), 32'(last_fault));
        if (last_chk) check({tag, ".b_rsp_rdata"}, bus.b_rsp_rdata, last_rdata);
    endtask

    task automatic idle_inputs();
        set_a(32'h0, 4'h0, 32'h0, 1'b0);
        set_b(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic b_write(input string tag, input logic [31:0] addr, input logic [31:0] wd);
        set_b(1'b1, 1'b1, addr, 4'hF, wd);
        step({tag, ".req"});
        set_b(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step({tag, ".rsp"});
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        b_busy     = 1'b0;
        last_rdata = 32'h0;
        last_fault = 1'b0;
        last_chk   = 1'b1;
        idle_inputs();

        // Reset values
        #2;
        check("rst.b_req_ready", 32'(bus.b_req_ready), 32'h0);
        check("rst.b_rsp_valid", 32'(bus.b_rsp_valid), 32'h0);
        check("rst.mem_rd_data", bus.mem_rd_data, 32'h0);
        check("rst.mem_fault",   32'(bus.mem_fault), 32'h0);
        check("rst.b_rsp_rdata", bus.b_rsp_rdata, 32'h0);
        check("rst.b_rsp_fault", 32'(bus.b_rsp_fault), 32'h0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;

        // 1: B preload, A read back
        b_write("t1_bw", 32'h10, 32'hDEAD_BEEF);
        set_a(32'h10, 4'h0, 32'h0, 1'b0);
        step("t1_ar");
        check("t1.value", bus.mem_rd_data, 32'hDEAD_BEEF);

        // 2: single-byte write
        set_a(32'h10, 4'b0010, 32'h0000_AB00, 1'b0);
        step("t2_aw");
        set_a(32'h10, 4'h0, 32'h0, 1'b0);
        step("t2_ar");
        check("t2.value", bus.mem_rd_data, 32'hDEAD_ABEF);

        // 3: read-first on port A
        idle_inputs();
        b_write("t3_pre", 32'h20, 32'hCAFE_F00D);
        set_a(32'h20, 4'hF, 32'h1111_1111, 1'b0);
        step("t3_rw");
        check("t3.old", bus.mem_rd_data, 32'hCAFE_F00D);
        set_a(32'h20, 4'h0, 32'h0, 1'b0);
        step("t3_ar");
        check("t3.new", bus.mem_rd_data, 32'h1111_1111);

        // 4: collision, B stalled one cycle then accepted
        set_a(32'h30, 4'hF, 32'h0, 1'b0);
        set_b(1'b1, 1'b1, 32'h30, 4'hF, 32'h5);
        step("t4_coll");
        set_a(32'h10, 4'h0, 32'h0, 1'b0);
        step("t4_acc");
        set_b(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step("t4_resp");
        set_a(32'h30, 4'h0, 32'h0, 1'b0);
        step("t4_ar");
        check("t4.value", bus.mem_rd_data, 32'h5);

        // 5: out of range on both ports, no aliasing onto word 0
        idle_inputs();
        b_write("t5_pre", 32'h0, 32'h0123_4567);
        set_a(32'h1000, 4'h0, 32'h0, 1'b0);
        step("t5_ar");
        set_a(32'hFFFF_FFFC, 4'hF, 32'hFFFF_FFFF, 1'b0);
        step("t5_aw");
        set_a(32'h10, 4'h0, 32'h0, 1'b0);
        b_write("t5_bw", 32'h1000, 32'h0000_0BAD);
        set_a(32'h0, 4'h0, 32'h0, 1'b0);
        step("t5_ar0");
        check("t5.word0", bus.mem_rd_data, 32'h0123_4567);

        // Same-word A write with B read: B sees the old value
        b_write("t7_pre", 32'h40, 32'hAAAA_5555);
        set_a(32'h40, 4'hF, 32'h1234_5678, 1'b0);
        set_b(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
        step("t7_awbr");
        set_a(32'h40, 4'h0, 32'h0, 1'b0);
        set_b(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step("t7_ar");

        // Different-word writes in one edge, then B read-back held through B_RESP
        set_a(32'h50, 4'hF, 32'h5050_5050, 1'b0);
        set_b(1'b1, 1'b1, 32'h54, 4'hF, 32'h5454_5454);
        step("t8_ww");
        set_a(32'h50, 4'h0, 32'h0, 1'b0);
        set_b(1'b1, 1'b0, 32'h54, 4'h0, 32'h0);
        step("t8_busy");
        step("t8_br");
        set_b(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step("t8_brsp");

        // A read with B write to same word: A sees the old value
        set_b(1'b1, 1'b1, 32'h50, 4'hF, 32'h0000_0077);
        step("t9_arbw");
        set_b(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step("t9_ar");

        // mem_rst clears the A output and blocks the A write
        set_a(32'h50, 4'hF, 32'h0000_0099, 1'b1);
        step("t10_rst");
        set_a(32'h50, 4'h0, 32'h0, 1'b0);
        step("t10_ar");
        check("t10.value", bus.mem_rd_data, 32'h0000_0077);

        // 6: async reset while in B_RESP drops the response
        set_b(1'b1, 1'b1, 32'h60, 4'hF, 32'h6666_6666);
        step("t6_req");
        set_b(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #2;
        Reset_n = 1'b0;
        #1;
        check("t6.b_rsp_valid", 32'(bus.b_rsp_valid), 32'h0);
        check("t6.mem_rd_data", bus.mem_rd_data, 32'h0);
        check("t6.b_req_ready", 32'(bus.b_req_ready), 32'h0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        #1;
        check("t6.ready_after", 32'(bus.b_req_ready), 32'h1);
        b_busy     = 1'b0;
        last_rdata = 32'h0;
        last_fault = 1'b0;
        last_chk   = 1'b1;
        exp_a_q.delete();
        exp_b_q.delete();
        set_a(32'h60, 4'h0, 32'h0, 1'b0);
        step("t6_idle0");
        step("t6_idle1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
